// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single common data bus between the result producers
// (src0 = ALU, src1 = load unit, src2 = branch unit). Each source owns a
// one-entry holding register; pending entries win the bus round-robin, one per
// cycle, and the winner is broadcast on a registered CDB.
// Build option: CDB_ARB_LOAD_PRIO_EN gives src1 (load) strict priority over
// the round-robin sources. The option applies only when NSRC > 1.

// Per-source holding register with its accept/ready handshake.
module cdb_hold #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              req_valid,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [DATA_W-1:0] req_val,
  input  logic [DATA_W-1:0] req_addr,
  input  logic              grant,
  output logic              req_ready,
  output logic              hv,
  output logic [TAG_W-1:0]  htag,
  output logic [DATA_W-1:0] hval,
  output logic [DATA_W-1:0] haddr
);

  logic acc;

  // An entry being broadcast this cycle frees its slot for a same-edge refill.
  assign req_ready = rdy_in & ~flush_in & (~hv | grant);
  assign acc       = req_valid & req_ready;

  // Valid bit: flush wins. A None tag is swallowed so it never reaches the bus.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)        hv <= 1'b0;
    else if (flush_in)  hv <= 1'b0;
    else if (acc)       hv <= (req_tag != '0);
    else if (grant)     hv <= 1'b0;
  end

  // Payload capture; the payload is only meaningful while hv is set.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      htag  <= '0;
      hval  <= '0;
      haddr <= '0;
    end else if (acc) begin
      htag  <= req_tag;
      hval  <= req_val;
      haddr <= req_addr;
    end
  end

endmodule

module cdb_arbiter #(
  parameter int NSRC   = 3,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  input  logic [NSRC-1:0]        req_valid,
  input  logic [NSRC*TAG_W-1:0]  req_tag,
  input  logic [NSRC*DATA_W-1:0] req_val,
  input  logic [NSRC*DATA_W-1:0] req_addr,
  output logic [NSRC-1:0]        req_ready,
  output logic                   cdb_active,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [DATA_W-1:0]      cdb_val,
  output logic [DATA_W-1:0]      cdb_addr
);

  localparam int PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;

`ifdef CDB_ARB_LOAD_PRIO_EN
  localparam bit LOAD_PRIO = (NSRC > 1);
`else
  localparam bit LOAD_PRIO = 1'b0;
`endif

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] addr;
  } cdb_ent_t;

  logic [NSRC-1:0]             hv;
  logic [NSRC-1:0]             grant;
  logic [NSRC-1:0][TAG_W-1:0]  htag;
  logic [NSRC-1:0][DATA_W-1:0] hval;
  logic [NSRC-1:0][DATA_W-1:0] haddr;
  logic [PTR_W-1:0]            last_grant;
  logic [PTR_W-1:0]            gnt_idx;
  logic                        gnt_any;
  cdb_ent_t                    cdb_q;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    cdb_hold #(
      .TAG_W (TAG_W),
      .DATA_W(DATA_W)
    ) u_hold (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rdy_in   (rdy_in),
      .flush_in (flush_in),
      .req_valid(req_valid[i]),
      .req_tag  (req_tag[i*TAG_W +: TAG_W]),
      .req_val  (req_val[i*DATA_W +: DATA_W]),
      .req_addr (req_addr[i*DATA_W +: DATA_W]),
      .grant    (grant[i]),
      .req_ready(req_ready[i]),
      .hv       (hv[i]),
      .htag     (htag[i]),
      .hval     (hval[i]),
      .haddr    (haddr[i])
    );
  end

  // Pick the first pending entry after last_grant (wrapping); a pending load
  // pre-empts the search when load priority is built in.
  always_comb begin
    int j;
    grant   = '0;
    gnt_idx = last_grant;
    gnt_any = 1'b0;
    j       = 0;
    if (rdy_in && !flush_in) begin
      if (LOAD_PRIO && hv[1]) begin
        gnt_any  = 1'b1;
        gnt_idx  = PTR_W'(1);
        grant[1] = 1'b1;
      end
      for (int k = 1; k <= NSRC; k++) begin
        j = (int'(last_grant) + k) % NSRC;
        if (!gnt_any && hv[j] && !(LOAD_PRIO && j == 1)) begin
          gnt_any  = 1'b1;
          gnt_idx  = PTR_W'(j);
          grant[j] = 1'b1;
        end
      end
    end
  end

  // Registered broadcast. Payload holds when idle; load grants under strict
  // priority leave the rotation pointer alone.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_active <= 1'b0;
      cdb_q      <= '0;
      last_grant <= PTR_W'(NSRC - 1);
    end else if (gnt_any) begin
      cdb_active <= 1'b1;
      cdb_q      <= '{tag: htag[gnt_idx], val: hval[gnt_idx], addr: haddr[gnt_idx]};
      if (!(LOAD_PRIO && gnt_idx == PTR_W'(1)))
        last_grant <= gnt_idx;
    end else begin
      cdb_active <= 1'b0;
    end
  end

  assign cdb_tag  = cdb_q.tag;
  assign cdb_val  = cdb_q.val;
  assign cdb_addr = cdb_q.addr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios followed by random traffic, every cycle
// compared against a pending-set reference model of the CDB arbiter.
module tb_cdb_arbiter;

  localparam int NSRC   = 3;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

`ifdef CDB_ARB_LOAD_PRIO_EN
  localparam bit LOAD_PRIO = 1'b1;
`else
  localparam bit LOAD_PRIO = 1'b0;
`endif

  logic                   clk_in = 1'b0;
  logic                   rst_in = 1'b0;
  logic                   rdy_in = 1'b0;
  logic                   flush_in = 1'b0;
  logic [NSRC-1:0]        req_valid = '0;
  logic [NSRC*TAG_W-1:0]  req_tag = '0;
  logic [NSRC*DATA_W-1:0] req_val = '0;
  logic [NSRC*DATA_W-1:0] req_addr = '0;
  logic [NSRC-1:0]        req_ready;
  logic                   cdb_active;
  logic [TAG_W-1:0]       cdb_tag;
  logic [DATA_W-1:0]      cdb_val;
  logic [DATA_W-1:0]      cdb_addr;

  cdb_arbiter #(.NSRC(NSRC), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush_in  (flush_in),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_val   (req_val),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .cdb_active(cdb_active),
    .cdb_tag   (cdb_tag),
    .cdb_val   (cdb_val),
    .cdb_addr  (cdb_addr)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model: pending entries per source, rotation point, expected bus.
  bit          mhv  [NSRC];
  logic [3:0]  mtag [NSRC];
  logic [31:0] mval [NSRC];
  logic [31:0] maddr[NSRC];
  int          mlast;
  bit          e_act;
  logic [3:0]  e_tag;
  logic [31:0] e_val, e_addr;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NSRC; i++) begin
      mhv[i] = 0; mtag[i] = '0; mval[i] = '0; maddr[i] = '0;
    end
    mlast = NSRC - 1;
    e_act = 0; e_tag = '0; e_val = '0; e_addr = '0;
  endtask

  function automatic int m_winner();
    if (!rdy_in || flush_in) return -1;
    if (LOAD_PRIO && mhv[1]) return 1;
    for (int k = 1; k <= NSRC; k++) begin
      int j;
      j = (mlast + k) % NSRC;
      if (LOAD_PRIO && j == 1) continue;
      if (mhv[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit m_ready(int i);
    return rdy_in && !flush_in && (!mhv[i] || m_winner() == i);
  endfunction

  task automatic model_edge();
    int w;
    bit rd[NSRC];
    w = m_winner();
    for (int i = 0; i < NSRC; i++) rd[i] = m_ready(i);
    if (w >= 0) begin
      e_act = 1; e_tag = mtag[w]; e_val = mval[w]; e_addr = maddr[w];
      mhv[w] = 0;
      if (!(LOAD_PRIO && w == 1)) mlast = w;
    end else begin
      e_act = 0;
    end
    if (flush_in) for (int i = 0; i < NSRC; i++) mhv[i] = 0;
    for (int i = 0; i < NSRC; i++)
      if (req_valid[i] && rd[i] && req_tag[i*TAG_W +: TAG_W] != '0) begin
        mhv[i]   = 1;
        mtag[i]  = req_tag[i*TAG_W +: TAG_W];
        mval[i]  = req_val[i*DATA_W +: DATA_W];
        maddr[i] = req_addr[i*DATA_W +: DATA_W];
      end
  endtask

  task automatic set_req(int i, logic [3:0] t, logic [31:0] v, logic [31:0] a);
    req_valid[i] = 1'b1;
    req_tag[i*TAG_W +: TAG_W]    = t;
    req_val[i*DATA_W +: DATA_W]  = v;
    req_addr[i*DATA_W +: DATA_W] = a;
  endtask

  task automatic clr_req();
    req_valid = '0; req_tag = '0; req_val = '0; req_addr = '0;
  endtask

  // One clock: check ready before the edge, advance model, check the bus after.
  task automatic cyc();
    #1;
    for (int i = 0; i < NSRC; i++)
      chk($sformatf("ready%0d", i), req_ready[i], m_ready(i));
    @(posedge clk_in);
    model_edge();
    #1;
    chk("cdb_active", cdb_active, e_act);
    chk("cdb_tag", cdb_tag, e_tag);
    chk("cdb_val", cdb_val, e_val);
    chk("cdb_addr", cdb_addr, e_addr);
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_in);
    chk("rst_active", cdb_active, 0);
    chk("rst_tag", cdb_tag, 0);
    chk("rst_val", cdb_val, 0);
    chk("rst_addr", cdb_addr, 0);
    rst_in = 1'b1;
  endtask

  initial begin
    int ord[3];
    int cnt[NSRC];
    bit rd[NSRC];
    int exp_src;

    rdy_in = 1'b1;
    do_reset();

    // Single request: one-cycle broadcast after the accept edge.
    set_req(0, 4'd3, 32'h0000_00AA, 32'h100);
    cyc();
    chk("single_e0_active", cdb_active, 0);
    clr_req();
    cyc();
    chk("single_active", cdb_active, 1);
    chk("single_tag", cdb_tag, 3);
    chk("single_val", cdb_val, 32'hAA);
    chk("single_addr", cdb_addr, 32'h100);
    cyc();
    chk("single_e2_active", cdb_active, 0);

    // Contention from reset.
    do_reset();
    set_req(0, 4'd1, 32'h11, 32'h10);
    set_req(1, 4'd2, 32'h22, 32'h20);
    set_req(2, 4'd3, 32'h33, 32'h30);
    cyc();
    clr_req();
    if (LOAD_PRIO) ord = '{2, 1, 3};
    else           ord = '{1, 2, 3};
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("cont_active%0d", k), cdb_active, 1);
      chk($sformatf("cont_tag%0d", k), cdb_tag, ord[k]);
    end
    cyc();
    chk("cont_idle", cdb_active, 0);

    // Back-to-back refill on src2.
    set_req(2, 4'd5, 32'h55, 32'h500);
    #1 chk("b2b_ready_a", req_ready[2], 1);
    cyc();
    set_req(2, 4'd6, 32'h66, 32'h600);
    #1 chk("b2b_ready_b", req_ready[2], 1);
    cyc();
    chk("b2b_tag5", cdb_tag, 5);
    chk("b2b_act5", cdb_active, 1);
    set_req(2, 4'd7, 32'h77, 32'h700);
    #1 chk("b2b_ready_c", req_ready[2], 1);
    cyc();
    chk("b2b_tag6", cdb_tag, 6);
    chk("b2b_act6", cdb_active, 1);
    clr_req();
    cyc();
    chk("b2b_tag7", cdb_tag, 7);
    chk("b2b_act7", cdb_active, 1);
    cyc();
    chk("b2b_idle", cdb_active, 0);

    // Backpressure / rotation with all sources streaming.
    do_reset();
    for (int i = 0; i < NSRC; i++) cnt[i] = 0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NSRC; i++)
        set_req(i, 4'(i + 1), {24'(cnt[i]), 8'(i)}, 32'h1000 + i);
      exp_src = LOAD_PRIO ? 1 : (k - 1) % NSRC;
      #1;
      if (k >= 1 && exp_src != 0) chk($sformatf("bp_ready0_%0d", k), req_ready[0], 0);
      for (int i = 0; i < NSRC; i++) rd[i] = m_ready(i);
      cyc();
      for (int i = 0; i < NSRC; i++) if (rd[i]) cnt[i]++;
      if (k >= 1) begin
        chk($sformatf("bp_act%0d", k), cdb_active, 1);
        chk($sformatf("bp_src%0d", k), cdb_val[7:0], exp_src);
      end
    end
    clr_req();
    repeat (4) cyc();

    // Flush beats pending entries and a same-cycle request.
    set_req(0, 4'd4, 32'h44, 32'h400);
    set_req(1, 4'd9, 32'h99, 32'h900);
    cyc();
    clr_req();
    set_req(2, 4'd8, 32'h88, 32'h800);
    flush_in = 1'b1;
    #1;
    for (int i = 0; i < NSRC; i++) chk($sformatf("flush_ready%0d", i), req_ready[i], 0);
    cyc();
    chk("flush_act0", cdb_active, 0);
    flush_in = 1'b0;
    clr_req();
    cyc();
    chk("flush_act1", cdb_active, 0);
    cyc();
    chk("flush_act2", cdb_active, 0);

    // Pause with a pending entry, single broadcast on resume.
    set_req(0, 4'd6, 32'h6666, 32'h6000);
    cyc();
    clr_req();
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("pause_act%0d", k), cdb_active, 0);
    end
    rdy_in = 1'b1;
    cyc();
    chk("resume_act", cdb_active, 1);
    chk("resume_tag", cdb_tag, 6);
    cyc();
    chk("resume_once", cdb_active, 0);

    // None tag accepted but never broadcast.
    set_req(1, 4'd0, 32'hDEAD, 32'hBEEF);
    #1 chk("none_ready", req_ready[1], 1);
    cyc();
    clr_req();
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("none_act%0d", k), cdb_active, 0);
    end

    // Reset in mid-operation drops the broadcast at once.
    set_req(0, 4'd5, 32'h5555, 32'h5000);
    cyc();
    clr_req();
    cyc();
    chk("midrst_pre", cdb_active, 1);
    #2 rst_in = 1'b0;
    #1;
    chk("midrst_act", cdb_active, 0);
    chk("midrst_tag", cdb_tag, 0);
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    cyc();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NSRC; i++)
        if ($urandom_range(0, 9) < 6)
          set_req(i, 4'($urandom_range(0, 15)), $urandom, $urandom);
        else
          req_valid[i] = 1'b0;
      rdy_in   = ($urandom_range(0, 7) != 0);
      flush_in = ($urandom_range(0, 19) == 0);
      cyc();
    end

    rdy_in = 1'b1;
    flush_in = 1'b0;
    clr_req();
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) result-broadcast port between the execution units that produce renamed results: src0 = ALU, src1 = load unit (LSB), src2 = branch/jump unit.
- Each source has a 1-entry holding register. Pending entries are granted round-robin, at most one per cycle.
- The winner is driven onto a registered CDB (cdb_active/tag/val/addr). The CDB feeds the register file, the RS and the LSB, where every entry with a matching dependency tag captures the value and clears its dependency.

Parameters:
- NSRC, 3, number of requesters (port index 0..NSRC-1).
- TAG_W, 4, rename tag width. Tag 0 is None.
- DATA_W, 32, result value and address width.

Ports:
- clk_in  in  1  clock; all state updates on the rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready. Low = pause.
- flush_in  in  1  mispredict flush. Discards all pending results.
- req_valid  in  NSRC  per-source result valid.
- req_tag  in  NSRC*TAG_W  packed per-source rename tags (src i at [i*TAG_W +: TAG_W]).
- req_val  in  NSRC*DATA_W  packed per-source result values.
- req_addr  in  NSRC*DATA_W  packed per-source addresses (branch target / load address).
- req_ready  out  NSRC  per-source acceptance.
- cdb_active  out  1  broadcast valid, registered.
- cdb_tag  out  TAG_W  broadcast tag, registered.
- cdb_val  out  DATA_W  broadcast value, registered.
- cdb_addr  out  DATA_W  broadcast address, registered.

Behaviour:
- Reset (rst_in low, asynchronous):
  - All holding-valid bits clear.
  - cdb_active=0, cdb_tag=0, cdb_val=0, cdb_addr=0.
  - Round-robin pointer last_grant = NSRC-1, so src0 has first priority.
- Holding register i: hv[i], htag[i], hval[i], haddr[i].
- Grant (combinational):
  - Candidate set is all i with hv[i]=1.
  - Search order starts at last_grant+1 and wraps modulo NSRC. The first candidate found wins.
  - No grant while rdy_in=0 or flush_in=1.
- Ready: req_ready[i] = rdy_in & ~flush_in & (~hv[i] | grant[i]). A source whose entry is being broadcast this cycle can refill in the same cycle.
- Accept: when req_valid[i] & req_ready[i] at a rising edge, capture tag/val/addr and set hv[i].
  - Exception: if req_tag[i]==0 (None), the result is accepted but discarded and hv[i] stays 0. It is never broadcast.
- Broadcast, at the edge where grant[g] is asserted:
  - cdb_active<=1; cdb_tag/val/addr <= held values of g.
  - hv[g] cleared (unless refilled the same edge); last_grant<=g.
  - Otherwise cdb_active<=0 and cdb_tag/val/addr hold their previous values.
- Latency: accept at edge E0, earliest broadcast visible after edge E1; cdb_active is high exactly one cycle per grant. Sustained throughput is 1 result/cycle total.
- Fairness: with all NSRC entries continuously pending, each source is granted once every NSRC cycles.
- flush_in=1 at an edge:
  - All hv cleared; cdb_active<=0; no accept that edge (flush beats simultaneous requests).
  - last_grant unchanged.
- rdy_in=0 at an edge:
  - hv, holding data and last_grant frozen; no accept, no grant.
  - cdb_active<=0, so no duplicate broadcast after resume.
- Reset asserted mid-operation: pending results are lost and cdb_active drops immediately.
- Tags are not checked for uniqueness across sources; the rename logic guarantees it.

Optional Feature:
- Macro CDB_ARB_LOAD_PRIO_EN.
- Defined: src1 (load) has strict priority. If hv[1]=1 it is granted regardless of last_grant, and last_grant is not updated by src1 grants. The remaining sources use round-robin among themselves.
- Undefined: pure round-robin as above.

Test Plan:
- Reset then single request: src0 valid, tag=3, val=0x0000_00AA, addr=0x100, at edge E0 -> after E1 cdb_active=1, cdb_tag=3, cdb_val=0xAA, cdb_addr=0x100 for one cycle; after E2 cdb_active=0.
- Contention: src0/1/2 all present tags 1/2/3 at the same edge, no further requests -> broadcasts in order tags 1,2,3 on three consecutive cycles. With CDB_ARB_LOAD_PRIO_EN: order 2,1,3.
- Back-to-back refill: src2 holds a request every cycle with tags 5,6,7 while no other source is active -> req_ready[2] stays 1 and the CDB shows 5,6,7 on consecutive cycles.
- Backpressure: src0 pending, plus src1 and src2 streaming -> req_ready[0]=0 while hv[0] is occupied and ungranted; rotation stays 0,1,2,0,...
- Flush: src0 tag=4 and src1 tag=9 pending, flush_in=1 for one cycle with a new src2 tag=8 request in the same cycle -> no broadcast of 4, 9 or 8, all req_ready=0 during the flush, and cdb_active=0 for the following two cycles.
- Pause and None tag:
  - rdy_in=0 for 3 cycles with tag=6 pending -> cdb_active=0 throughout; tag 6 broadcast exactly once in the first cycle after rdy_in returns high.
  - A request with tag=0 -> accepted, never broadcast.
